// File: rtl/freelist_ckpt_pkg.sv
// Shared types and pointer helpers for the checkpointed physical-register free list.
package freelist_ckpt_pkg;

  localparam int unsigned FL_N          = 3;
  localparam int unsigned FL_PR_COUNT   = 64;
  localparam int unsigned FL_ARCH_COUNT = 32;
  localparam int unsigned FL_CKPT_COUNT = 8;
  localparam int unsigned FL_D          = FL_PR_COUNT - FL_ARCH_COUNT;
  localparam int unsigned FL_PW         = $clog2(FL_PR_COUNT);
  localparam int unsigned FL_PTRW       = $clog2(2 * FL_D);
  localparam int unsigned FL_CKW        = $clog2(FL_CKPT_COUNT);

  typedef logic [FL_PW-1:0]   preg_idx_t;
  typedef logic [FL_CKW-1:0]  ckpt_id_t;
  typedef logic [FL_PTRW-1:0] fl_ptr_t;

  // Pointers run over 0..2*depth-1 so that full and empty are distinguishable.
  function automatic int unsigned ptr_add(int unsigned ptr, int unsigned inc, int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= 2 * depth) ? sum - 2 * depth : sum;
  endfunction

  function automatic int unsigned ptr_to_idx(int unsigned ptr, int unsigned depth);
    return (ptr < depth) ? ptr : ptr - depth;
  endfunction

  function automatic int unsigned ptr_dist(int unsigned a, int unsigned b, int unsigned depth);
    return (a >= b) ? a - b : a + 2 * depth - b;
  endfunction

endpackage

// File: rtl/freelist_ckpt_lane_compact.sv
// Prefix popcount: each lane gets the count of set request bits below it.
module freelist_ckpt_lane_compact #(
  parameter int unsigned WIDTH = 3,
  localparam int unsigned CNTW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]           req,
  output logic [WIDTH-1:0][CNTW-1:0] offset,
  output logic [CNTW-1:0]            count
);

  logic [CNTW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      offset[i] = acc;
      acc       = acc + CNTW'(req[i]);
    end
    count = acc;
  end

endmodule

// File: rtl/freelist_ckpt.sv
// Circular-FIFO physical register free list with branch checkpoints and a committed head
// for exception flush.
module freelist_ckpt
  import freelist_ckpt_pkg::*;
#(
  parameter int unsigned ALLOC_WIDTH = FL_N,
  parameter int unsigned FREE_WIDTH  = FL_N,
  parameter int unsigned PR_COUNT    = FL_PR_COUNT,
  parameter int unsigned ARCH_COUNT  = FL_ARCH_COUNT,
  parameter int unsigned CKPT_COUNT  = FL_CKPT_COUNT,
  localparam int unsigned D    = PR_COUNT - ARCH_COUNT,
  localparam int unsigned PW   = $clog2(PR_COUNT),
  localparam int unsigned CW   = $clog2(D + 1),
  localparam int unsigned CKW  = $clog2(CKPT_COUNT)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ALLOC_WIDTH-1:0]          alloc_req,
  output logic                            alloc_ok,
  output logic [ALLOC_WIDTH-1:0][PW-1:0]  alloc_preg,
  input  logic [FREE_WIDTH-1:0]           free_valid,
  input  logic [FREE_WIDTH-1:0][PW-1:0]   free_preg,
  input  logic [FREE_WIDTH-1:0]           commit_valid,
  input  logic                            ckpt_take,
  input  logic [CKW-1:0]                  ckpt_take_id,
  input  logic                            ckpt_restore,
  input  logic [CKW-1:0]                  ckpt_restore_id,
  input  logic                            flush,
  output logic [CW-1:0]                   free_slots
);

  localparam int unsigned PTRW = $clog2(2 * D);
  localparam int unsigned IW   = $clog2(D);
  localparam int unsigned AW   = $clog2(ALLOC_WIDTH + 1);
  localparam int unsigned FW   = $clog2(FREE_WIDTH + 1);

  logic [PW-1:0]   entries_q [D];
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d, commit_head_q, commit_head_d;
  logic [PTRW-1:0] ckpt_head_q [CKPT_COUNT];
  logic [CKPT_COUNT-1:0] ckpt_written_q;
  logic [CW-1:0]   free_slots_q, free_count;

  logic [ALLOC_WIDTH-1:0][AW-1:0] alloc_off;
  logic [AW-1:0]                  alloc_cnt;
  logic [FREE_WIDTH-1:0][FW-1:0]  free_off;
  logic [FW-1:0]                  free_cnt;
  logic [FW-1:0]                  commit_cnt;

  freelist_ckpt_lane_compact #(.WIDTH(ALLOC_WIDTH)) u_alloc_compact (
    .req    (alloc_req),
    .offset (alloc_off),
    .count  (alloc_cnt)
  );

  freelist_ckpt_lane_compact #(.WIDTH(FREE_WIDTH)) u_free_compact (
    .req    (free_valid),
    .offset (free_off),
    .count  (free_cnt)
  );

  always_comb begin
    free_count = CW'(ptr_dist(32'(tail_q), 32'(head_q), D));
    alloc_ok   = (32'(alloc_cnt) <= 32'(free_count)) && !flush && !ckpt_restore;
    alloc_preg = '0;
    for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_preg[i] = entries_q[IW'(ptr_to_idx(ptr_add(32'(head_q), 32'(alloc_off[i]), D), D))];
    end

    commit_cnt = '0;
    for (int unsigned i = 0; i < FREE_WIDTH; i++) begin
      commit_cnt = commit_cnt + FW'(commit_valid[i]);
    end
    commit_head_d = PTRW'(ptr_add(32'(commit_head_q), 32'(commit_cnt), D));
    tail_d        = PTRW'(ptr_add(32'(tail_q), 32'(free_cnt), D));

    // Flush beats restore; both suppress allocation via alloc_ok.
    if (flush) begin
      head_d = commit_head_d;
    end else if (ckpt_restore) begin
      head_d = ckpt_head_q[ckpt_restore_id];
    end else if (alloc_ok) begin
      head_d = PTRW'(ptr_add(32'(head_q), 32'(alloc_cnt), D));
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q         <= '0;
      tail_q         <= PTRW'(D);
      commit_head_q  <= '0;
      free_slots_q   <= CW'(D);
      ckpt_written_q <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        entries_q[i] <= PW'(ARCH_COUNT + i);
      end
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      commit_head_q <= commit_head_d;
      free_slots_q  <= CW'(ptr_dist(32'(tail_d), 32'(head_d), D));
      for (int unsigned i = 0; i < FREE_WIDTH; i++) begin
        if (free_valid[i]) begin
          entries_q[IW'(ptr_to_idx(ptr_add(32'(tail_q), 32'(free_off[i]), D), D))] <= free_preg[i];
        end
      end
      // head_d already includes this cycle's grant, so the bundle keeps its own pregs.
      if (ckpt_take && !flush && !ckpt_restore) begin
        ckpt_head_q[ckpt_take_id]    <= head_d;
        ckpt_written_q[ckpt_take_id] <= 1'b1;
      end
    end
  end

  assign free_slots = free_slots_q;

  a_free_overflow: assert property (@(posedge clock) disable iff (reset)
    32'(free_count) + 32'(free_cnt) <= D)
    else $error("free list overflow");

  a_commit_passes_head: assert property (@(posedge clock) disable iff (reset)
    32'(commit_cnt) <= ptr_dist(32'(head_q), 32'(commit_head_q), D))
    else $error("commit head passes head");

  a_restore_unwritten: assert property (@(posedge clock) disable iff (reset)
    (ckpt_restore && !flush) |-> ckpt_written_q[ckpt_restore_id])
    else $error("restore of unwritten checkpoint");

endmodule

// File: tb/tb_freelist_ckpt.sv
// Scoreboard bench for freelist_ckpt: driver queues expected responses, a negedge monitor checks.
module tb_freelist_ckpt;
  import freelist_ckpt_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [2:0]           alloc_req;
  logic                 alloc_ok;
  logic [2:0][5:0]      alloc_preg;
  logic [2:0]           free_valid;
  logic [2:0][5:0]      free_preg;
  logic [2:0]           commit_valid;
  logic                 ckpt_take;
  ckpt_id_t             ckpt_take_id;
  logic                 ckpt_restore;
  ckpt_id_t             ckpt_restore_id;
  logic                 flush;
  logic [5:0]           free_slots;

  always #5 clock = ~clock;

  freelist_ckpt dut (
    .clock           (clock),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .alloc_ok        (alloc_ok),
    .alloc_preg      (alloc_preg),
    .free_valid      (free_valid),
    .free_preg       (free_preg),
    .commit_valid    (commit_valid),
    .ckpt_take       (ckpt_take),
    .ckpt_take_id    (ckpt_take_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .flush           (flush),
    .free_slots      (free_slots)
  );

  typedef struct packed {
    logic [127:0]    name;
    bit              chk_ok;
    bit              exp_ok;
    logic [2:0]      lmask;
    preg_idx_t [2:0] epreg;
    bit              chk_slots;
    logic [5:0]      eslots;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic clear_inputs();
    alloc_req       = '0;
    free_valid      = '0;
    free_preg       = '0;
    commit_valid    = '0;
    ckpt_take       = 1'b0;
    ckpt_take_id    = '0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
    flush           = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  // es < 0 skips the free_slots check.
  task automatic expect_cyc(input logic [127:0] nm, input bit chk_ok, input bit exp_ok,
                            input logic [2:0] lmask, input logic [2:0][5:0] ep, input int es);
    exp_t e;
    e.name      = nm;
    e.chk_ok    = chk_ok;
    e.exp_ok    = exp_ok;
    e.lmask     = lmask;
    e.epreg     = ep;
    e.chk_slots = (es >= 0);
    e.eslots    = 6'(es);
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk_ok) begin
          checks++;
          if (alloc_ok !== e.exp_ok) begin
            failures++;
            $display("FAIL %0s alloc_ok got=%0b exp=%0b", e.name, alloc_ok, e.exp_ok);
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (e.lmask[i]) begin
            checks++;
            if (alloc_preg[i] !== e.epreg[i]) begin
              failures++;
              $display("FAIL %0s preg[%0d] got=%0d exp=%0d", e.name, i, alloc_preg[i],
                       e.epreg[i]);
            end
          end
        end
        if (e.chk_slots) begin
          checks++;
          if (free_slots !== e.eslots) begin
            failures++;
            $display("FAIL %0s free_slots got=%0d exp=%0d", e.name, free_slots, e.eslots);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state: head=0 tail=32, entries[i]=32+i
    alloc_req = 3'b111;
    expect_cyc("alloc3", 1, 1, 3'b111, {6'd34, 6'd33, 6'd32}, 32);
    tick();
    expect_cyc("k0_ok", 1, 1, 3'b000, '0, 29);
    tick();
    alloc_req = 3'b101;
    expect_cyc("sparse", 1, 1, 3'b101, {6'd36, 6'd0, 6'd35}, 29);

    // Drain down to two free entries
    for (int j = 0; j < 8; j++) begin
      tick();
      alloc_req = 3'b111;
      expect_cyc("drain", 1, 1, 3'b111,
                 {6'(39 + 3 * j), 6'(38 + 3 * j), 6'(37 + 3 * j)}, 27 - 3 * j);
    end
    tick();
    alloc_req = 3'b001;
    expect_cyc("drain1", 1, 1, 3'b001, {6'd0, 6'd0, 6'd61}, 3);

    tick();
    alloc_req  = 3'b111;
    free_valid = 3'b011;
    free_preg  = {6'd0, 6'd41, 6'd40};
    expect_cyc("short", 1, 0, 3'b000, '0, 2);
    tick();
    alloc_req = 3'b111;
    expect_cyc("wrap_alloc", 1, 1, 3'b111, {6'd40, 6'd63, 6'd62}, 4);

    // Refill to full across the pointer wrap
    tick();
    free_valid = 3'b101;
    free_preg  = {6'd2, 6'd63, 6'd1};
    expect_cyc("sparse_free", 0, 0, 3'b000, '0, 1);
    for (int j = 0; j < 9; j++) begin
      tick();
      free_valid = 3'b111;
      free_preg  = {6'(5 + 3 * j), 6'(4 + 3 * j), 6'(3 + 3 * j)};
      expect_cyc("refill", 0, 0, 3'b000, '0, 3 + 3 * j);
    end
    tick();
    free_valid = 3'b011;
    free_preg  = {6'd0, 6'd31, 6'd30};
    expect_cyc("refill_last", 0, 0, 3'b000, '0, 30);
    tick();
    alloc_req = 3'b111;
    expect_cyc("full", 1, 1, 3'b111, {6'd2, 6'd1, 6'd41}, 32);

    // Checkpoint take with own allocation, then restore
    tick();
    alloc_req    = 3'b011;
    ckpt_take    = 1'b1;
    ckpt_take_id = 3'd2;
    expect_cyc("ckpt_take", 1, 1, 3'b011, {6'd0, 6'd4, 6'd3}, 29);
    tick();
    alloc_req = 3'b111;
    expect_cyc("post_a", 1, 1, 3'b111, {6'd7, 6'd6, 6'd5}, 27);
    tick();
    alloc_req = 3'b111;
    expect_cyc("post_b", 1, 1, 3'b111, {6'd10, 6'd9, 6'd8}, 24);
    tick();
    alloc_req = 3'b111;
    expect_cyc("post_c", 1, 1, 3'b111, {6'd13, 6'd12, 6'd11}, 21);
    tick();
    alloc_req       = 3'b111;
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 3'd2;
    free_valid      = 3'b001;
    free_preg       = {6'd0, 6'd0, 6'd40};
    expect_cyc("restore", 1, 0, 3'b000, '0, 18);
    tick();
    alloc_req = 3'b001;
    expect_cyc("after_rst", 1, 1, 3'b001, {6'd0, 6'd0, 6'd5}, 28);

    // Commit everything outstanding
    for (int j = 0; j < 13; j++) begin
      tick();
      commit_valid = 3'b111;
      expect_cyc("commit", 0, 0, 3'b000, '0, 27);
    end

    // Ten allocations, four commits, then flush racing a restore
    tick();
    alloc_req = 3'b111;
    expect_cyc("fl_a", 1, 1, 3'b111, {6'd8, 6'd7, 6'd6}, 27);
    tick();
    alloc_req = 3'b111;
    expect_cyc("fl_b", 1, 1, 3'b111, {6'd11, 6'd10, 6'd9}, 24);
    tick();
    alloc_req = 3'b111;
    expect_cyc("fl_c", 1, 1, 3'b111, {6'd14, 6'd13, 6'd12}, 21);
    tick();
    alloc_req = 3'b001;
    expect_cyc("fl_d", 1, 1, 3'b001, {6'd0, 6'd0, 6'd15}, 18);
    tick();
    commit_valid = 3'b111;
    expect_cyc("fl_commit", 0, 0, 3'b000, '0, 17);
    tick();
    commit_valid    = 3'b001;
    flush           = 1'b1;
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 3'd2;
    alloc_req       = 3'b111;
    free_valid      = 3'b001;
    free_preg       = {6'd0, 6'd0, 6'd50};
    expect_cyc("flush", 1, 0, 3'b000, '0, 17);
    tick();
    alloc_req = 3'b001;
    expect_cyc("after_fl", 1, 1, 3'b001, {6'd0, 6'd0, 6'd10}, 24);
    tick();
    expect_cyc("final", 0, 0, 3'b000, '0, 23);
    tick();

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clock);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_queue pending=%0d exp=0", sb_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
